bcd2bin: RTL and testbench



---
 rtl/bcd2bin.sv | 147 ++++++++++++++
 tb/tb_bcd2bin.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble) with a
// start/done handshake and an illegal-digit flag.
module bcd2bin #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  done,
    output logic                  err,
    output logic                  busy
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CAT_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BCD_W-1:0]   bcd_d;
    logic [BIN_W-1:0]   bin_reg;
    logic [BIN_W-1:0]   bin_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic               bad;
    logic               bad_d;
    logic [BIN_W-1:0]   bin_out_d;
    logic               err_d;
    logic               done_d;
    logic               busy_d;
    logic [CAT_W-1:0]   shift_cat;

    // Subtract 3 from every digit that reached 8 or more after the shift.
    function automatic logic [BCD_W-1:0] fix_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] >= 4'd8) begin
                r[4*i +: 4] = v[4*i +: 4] - 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [BCD_W-1:0] v);
        logic b;
        b = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                b = 1'b1;
            end
        end
        return b;
    endfunction

    assign shift_cat = {bcd_reg, bin_reg} >> 1;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; an illegal operand spends one SHIFT cycle without
    // shifting, giving the error path a fixed two-cycle latency.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (bad || (cnt == CNT_W'(BIN_W - 1))) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values for the datapath and the registered outputs.
    always_comb begin
        bcd_d     = bcd_reg;
        bin_d     = bin_reg;
        cnt_d     = cnt;
        bad_d     = bad;
        bin_out_d = bin_out;
        err_d     = err;
        done_d    = 1'b0;
        busy_d    = (next_state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    bcd_d = bcd_in;
                    bin_d = '0;
                    cnt_d = '0;
                    bad_d = has_bad(bcd_in);
                end
            end
            SHIFT: begin
                if (!bad) begin
                    bcd_d = fix_digits(shift_cat[CAT_W-1 -: BCD_W]);
                    bin_d = shift_cat[BIN_W-1:0];
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            FINISH: begin
                done_d    = 1'b1;
                bin_out_d = bad ? '0 : bin_reg;
                err_d     = bad;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            bad     <= 1'b0;
            bin_out <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            bcd_reg <= bcd_d;
            bin_reg <= bin_d;
            cnt     <= cnt_d;
            bad     <= bad_d;
            bin_out <= bin_out_d;
            err     <= err_d;
            done    <= done_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: directed and random operands against a
// decimal-arithmetic reference, plus handshake, busy and reset scenarios.
module tb_bcd2bin;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] bcd_in;
    logic [13:0] bin_out;
    logic        done;
    logic        err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd2bin #(.DIGITS(4), .BIN_W(14)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .done    (done),
        .err     (err),
        .busy    (busy)
    );

    // Reference: decimal value of the digits, or (0, bad) if any digit exceeds 9.
    function automatic void model(input logic [15:0] b, output int val, output bit bad);
        logic [15:0] t;
        int d;
        val = 0;
        bad = 1'b0;
        t   = b;
        for (int i = 3; i >= 0; i--) begin
            d = int'((t >> (4 * i)) & 16'hF);
            if (d > 9) bad = 1'b1;
            val = val * 10 + d;
        end
        if (bad) val = 0;
    endfunction

    // Starts one conversion from IDLE and measures edges until done.
    task automatic run_conv(input logic [15:0] b, output int lat, output logic [13:0] r_bin,
                            output logic r_err, output logic r_busy, output logic r_done_next);
        lat    = -1;
        r_bin  = '0;
        r_err  = 1'b0;
        r_busy = 1'b1;
        bcd_in = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = 16'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat    = k;
                r_bin  = bin_out;
                r_err  = err;
                r_busy = busy;
                break;
            end
        end
        @(posedge clk);
        #1;
        r_done_next = done;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b1;
        bcd_in = 16'h0189;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bin_out !== 14'd0) begin errors++; $display("FAIL reset_bin got %0d want 0", bin_out); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [15:0] ops [5];
        int lat, ev, exp_lat;
        bit eb;
        logic [13:0] rb;
        logic re, rbusy, rdn;
        ops[0] = 16'h0189; ops[1] = 16'h9999; ops[2] = 16'h0000;
        ops[3] = 16'h12A4; ops[4] = 16'h0042;
        foreach (ops[j]) begin
            model(ops[j], ev, eb);
            exp_lat = eb ? 2 : 15;
            run_conv(ops[j], lat, rb, re, rbusy, rdn);
            checks++; if (lat != exp_lat) begin errors++; $display("FAIL dir_latency op=%h got %0d want %0d", ops[j], lat, exp_lat); end
            checks++; if (int'(rb) != ev) begin errors++; $display("FAIL dir_bin op=%h got %0d want %0d", ops[j], rb, ev); end
            checks++; if (re !== eb) begin errors++; $display("FAIL dir_err op=%h got %b want %b", ops[j], re, eb); end
            checks++; if (rbusy !== 1'b0) begin errors++; $display("FAIL dir_busy_at_done op=%h got %b want 0", ops[j], rbusy); end
            checks++; if (rdn !== 1'b0) begin errors++; $display("FAIL dir_done_width op=%h got %b want 0", ops[j], rdn); end
        end
    endtask

    task automatic test_random();
        logic [15:0] b;
        int lat, ev;
        bit eb;
        logic [13:0] rb;
        logic re, rbusy, rdn;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = 16'($urandom);
            end else begin
                b = '0;
                for (int i = 0; i < 4; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            model(b, ev, eb);
            run_conv(b, lat, rb, re, rbusy, rdn);
            checks++; if (int'(rb) != ev) begin errors++; $display("FAIL rnd_bin op=%h got %0d want %0d", b, rb, ev); end
            checks++; if (re !== eb) begin errors++; $display("FAIL rnd_err op=%h got %b want %b", b, re, eb); end
            checks++; if (lat != (eb ? 2 : 15)) begin errors++; $display("FAIL rnd_latency op=%h got %0d want %0d", b, lat, eb ? 2 : 15); end
        end
    endtask

    task automatic test_busy_ignore();
        int ndone, first;
        logic [13:0] fb;
        ndone = 0; first = -1; fb = '0;
        bcd_in = 16'h0500;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bcd_in = 16'h0777;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %b want 1", busy); end
        for (int k = 7; k <= 46; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first < 0) begin first = k; fb = bin_out; end
            end
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", ndone); end
        checks++; if (first != 15) begin errors++; $display("FAIL ign_latency got %0d want 15", first); end
        checks++; if (fb !== 14'd500) begin errors++; $display("FAIL ign_bin got %0d want 500", fb); end
    endtask

    task automatic test_back_to_back();
        int q[$];
        logic prev;
        int extra;
        prev   = 1'b0;
        bcd_in = 16'h1234;
        start  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                q.push_back(k);
                checks++; if (bin_out !== 14'd1234) begin errors++; $display("FAIL b2b_bin edge=%0d got %0d want 1234", k, bin_out); end
                checks++; if (prev !== 1'b0) begin errors++; $display("FAIL b2b_stretch edge=%0d got prev=%b want 0", k, prev); end
            end
            prev = done;
        end
        start = 1'b0;
        checks++; if (q.size() != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", q.size()); end
        if (q.size() >= 2) begin
            checks++; if (q[0] != 16) begin errors++; $display("FAIL b2b_first got %0d want 16", q[0]); end
            checks++; if (q[1] - q[0] != 16) begin errors++; $display("FAIL b2b_spacing got %0d want 16", q[1] - q[0]); end
        end
        // A third conversion was accepted before start dropped; let it drain.
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        checks++; if (extra != 1) begin errors++; $display("FAIL b2b_drain got %0d want 1", extra); end
    endtask

    task automatic test_reset_mid();
        int ndone, lat;
        logic [13:0] rb;
        logic re, rbusy, rdn;
        bcd_in = 16'h0189;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bin_out !== 14'd0) begin errors++; $display("FAIL rstmid_bin got %0d want 0", bin_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rstmid_flags got done=%b err=%b want 0 0", done, err); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", ndone); end
        run_conv(16'h0189, lat, rb, re, rbusy, rdn);
        checks++; if (lat != 15) begin errors++; $display("FAIL rstmid_latency got %0d want 15", lat); end
        checks++; if (rb !== 14'd189) begin errors++; $display("FAIL rstmid_bin_after got %0d want 189", rb); end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
